// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: two-requester front end sharing one combinational
// single-precision divider.
//   main_div      : combinational a/b, truncating, no denormal or special
//                   value handling. Hidden bit is always taken as 1.
//                   Overflow gives signed infinity, underflow gives signed zero.
//   fp_div_arbiter: round-robin grant -> EXEC (capture divider outputs) ->
//                   RESP (hold until rsp_valid && rsp_ready).
// Ports (fp_div_arbiter):
//   clk, rst                      clock, async active-high reset
//   reqN_valid/a/b, reqN_ready    requester N operand handshake (ready is combinational)
//   rsp_valid/ready/id/m          response handshake, owner id and quotient
//   rsp_overflow/underflow/dbz    divider flags, divide-by-zero flag
//   done_cnt                      completed response count (wraps at 256)

module main_div (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] m,
  output logic        overflow,
  output logic        underflow
);

  // Restoring division of n by d, where d <= n < 2d. The leading quotient bit
  // is known to be 1, so it is consumed by the first subtraction and only the
  // 23 fraction bits are returned.
  function automatic logic [22:0] frac_div(input logic [24:0] n, input logic [23:0] d);
    logic [24:0] r;
    logic [22:0] q;
    r = (n - {1'b0, d}) << 1;
    for (int i = 22; i >= 0; i--) begin
      if (r >= {1'b0, d}) begin
        q[i] = 1'b1;
        r    = r - {1'b0, d};
      end else begin
        q[i] = 1'b0;
      end
      r = r << 1;
    end
    return q;
  endfunction

  logic               sign_s;
  logic               norm_s;
  logic [23:0]        d_s;
  logic [24:0]        n_s;
  logic [22:0]        frac_s;
  logic signed [9:0]  exp_s;

  // Quotient datapath: pre-normalise the dividend so the significand ratio lies in [1,2).
  always_comb begin
    sign_s = a[31] ^ b[31];
    d_s    = {1'b1, b[22:0]};
    norm_s = ({1'b1, a[22:0]} >= d_s);
    if (norm_s) begin
      n_s = {1'b0, 1'b1, a[22:0]};
    end else begin
      n_s = {1'b1, a[22:0], 1'b0};
    end
    frac_s    = frac_div(n_s, d_s);
    exp_s     = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
              + (norm_s ? 10'sd127 : 10'sd126);
    overflow  = (exp_s > 10'sd254);
    underflow = (exp_s < 10'sd1);
    if (overflow) begin
      m = {sign_s, 8'hFF, 23'h000000};
    end else if (underflow) begin
      m = {sign_s, 31'h00000000};
    end else begin
      m = {sign_s, exp_s[7:0], frac_s};
    end
  end

endmodule

module fp_div_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  req1_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_m,
  output logic                  rsp_overflow,
  output logic                  rsp_underflow,
  output logic                  rsp_dbz,
  output logic [7:0]            done_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                state_r, state_s;
  logic                  last_grant_r;
  logic                  op_id_r;
  logic [DATA_WIDTH-1:0] op_a_r, op_b_r;
  logic                  any_req_s, grant_s, gnt_id_s;
  logic [DATA_WIDTH-1:0] div_m_s;
  logic                  div_ovf_s, div_unf_s;

  main_div u_main_div (
    .a         (op_a_r),
    .b         (op_b_r),
    .m         (div_m_s),
    .overflow  (div_ovf_s),
    .underflow (div_unf_s)
  );

  // Round-robin pick: a tie goes to the requester not granted last time.
  always_comb begin
    any_req_s  = req0_valid | req1_valid;
    gnt_id_s   = (req0_valid & req1_valid) ? ~last_grant_r : req1_valid;
    grant_s    = (state_r == IDLE) & any_req_s & ~rst;
    req0_ready = grant_s & ~gnt_id_s;
    req1_ready = grant_s & gnt_id_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = any_req_s ? EXEC : IDLE;
      EXEC:    state_s = RESP;
      RESP:    state_s = rsp_ready ? IDLE : RESP;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand capture and round-robin pointer, both updated only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r       <= {DATA_WIDTH{1'b0}};
      op_b_r       <= {DATA_WIDTH{1'b0}};
      op_id_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (grant_s) begin
      op_a_r       <= gnt_id_s ? req1_a : req0_a;
      op_b_r       <= gnt_id_s ? req1_b : req0_b;
      op_id_r      <= gnt_id_s;
      last_grant_r <= gnt_id_s;
    end
  end

  // Response registers: loaded in EXEC, released on the RESP handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_m         <= {DATA_WIDTH{1'b0}};
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
      rsp_dbz       <= 1'b0;
      done_cnt      <= 8'd0;
    end else begin
      case (state_r)
        EXEC: begin
          rsp_valid     <= 1'b1;
          rsp_id        <= op_id_r;
          rsp_m         <= div_m_s;
          rsp_overflow  <= div_ovf_s;
          rsp_underflow <= div_unf_s;
          rsp_dbz       <= (op_b_r[DATA_WIDTH-2:0] == {(DATA_WIDTH-1){1'b0}});
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
